// File: rtl/fda_serial_pkg.sv
// Shared definitions for the serial framing path (accumulator -> framer -> TX).
// Contents:
//   SYNC0 / SYNC1   frame preamble bytes
//   framer_state_e  adc_packet_framer state encoding
//   csumClose()     two's-complement closer so that the covered bytes plus CSUM sum to 0
package fda_serial_pkg;

  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC0,
    ST_SYNC1,
    ST_SEQ,
    ST_LEN_H,
    ST_LEN_L,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_CSUM
  } framer_state_e;

  function automatic logic [7:0] csumClose(input logic [7:0] sum);
    return ~sum + 8'd1;
  endfunction

endpackage

// File: rtl/adc_packet_framer.sv
// adc_packet_framer
// Pulls PAYLOAD_LEN stored ADC bytes from the peak accumulator, one request at a
// time, and emits the frame  AA 55 SEQ LEN_H LEN_L payload CSUM  over a valid/ready
// byte handshake to the serial transmitter.
// Ports:
//   Clock      system clock (only clock in the block)
//   Reset      asynchronous, active-high
//   DataReady  level, accumulator holds a captured burst
//   DataValid  1-cycle pulse, DataIn valid
//   DataIn     stored ADC byte
//   DataRead   1-cycle request for the next stored byte
//   TxByte     frame byte to transmitter
//   TxValid    TxByte valid
//   TxReady    transmitter accepts TxByte on TxValid & TxReady
//   Busy       high from leaving IDLE until CSUM is accepted
//   Timeout    sticky, a payload byte was padded; cleared at next frame start
module adc_packet_framer
  import fda_serial_pkg::*;
#(
  parameter int PAYLOAD_LEN = 128,
  parameter int TIMEOUT     = 255
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       DataReady,
  input  logic       DataValid,
  input  logic [7:0] DataIn,
  output logic       DataRead,
  output logic [7:0] TxByte,
  output logic       TxValid,
  input  logic       TxReady,
  output logic       Busy,
  output logic       Timeout
);

  localparam int              TW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [15:0]     LEN16  = 16'(PAYLOAD_LEN);
  localparam logic [TW-1:0]   TO_LIM = TW'(TIMEOUT);

  framer_state_e   state, nextState;
  logic [7:0]      seq;
  logic [7:0]      csum;
  logic [15:0]     byteCnt;
  logic [TW-1:0]   toCnt;
  logic [7:0]      payload;
  logic            timeoutQ;
  logic            xfer;
  logic            lastByte;

  assign xfer     = TxValid & TxReady;
  assign lastByte = (byteCnt + 16'd1) == LEN16;
  assign Busy     = (state != ST_IDLE);
  assign Timeout  = timeoutQ;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      ST_IDLE:  if (DataReady) nextState = ST_SYNC0;
      ST_SYNC0: if (xfer) nextState = ST_SYNC1;
      ST_SYNC1: if (xfer) nextState = ST_SEQ;
      ST_SEQ:   if (xfer) nextState = ST_LEN_H;
      ST_LEN_H: if (xfer) nextState = ST_LEN_L;
      ST_LEN_L: if (xfer) nextState = ST_REQ;
      // A response in the request cycle itself skips WAIT entirely.
      ST_REQ:   nextState = DataValid ? ST_SEND : ST_WAIT;
      ST_WAIT:  if (DataValid || toCnt == TO_LIM) nextState = ST_SEND;
      ST_SEND:  if (xfer) nextState = lastByte ? ST_CSUM : ST_REQ;
      ST_CSUM:  if (xfer) nextState = ST_IDLE;
      default:  nextState = ST_IDLE;
    endcase
  end

  // Outputs: everything decodes from registered state/data, so TxByte and
  // TxValid cannot move while the transmitter stalls. DataRead only occurs in
  // REQ where TxValid is low, so it never overlaps a stalled byte.
  always_comb begin
    TxValid  = 1'b0;
    TxByte   = 8'h00;
    DataRead = 1'b0;
    unique case (state)
      ST_SYNC0: begin TxValid = 1'b1; TxByte = SYNC0;           end
      ST_SYNC1: begin TxValid = 1'b1; TxByte = SYNC1;           end
      ST_SEQ:   begin TxValid = 1'b1; TxByte = seq;             end
      ST_LEN_H: begin TxValid = 1'b1; TxByte = LEN16[15:8];     end
      ST_LEN_L: begin TxValid = 1'b1; TxByte = LEN16[7:0];      end
      ST_REQ:   DataRead = 1'b1;
      ST_SEND:  begin TxValid = 1'b1; TxByte = payload;         end
      ST_CSUM:  begin TxValid = 1'b1; TxByte = csumClose(csum); end
      default:  ;
    endcase
  end

  // Datapath: sequence number, running checksum, byte and timeout counters.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      seq      <= 8'h00;
      csum     <= 8'h00;
      byteCnt  <= 16'h0000;
      toCnt    <= '0;
      payload  <= 8'h00;
      timeoutQ <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (DataReady) begin
          csum     <= 8'h00;
          byteCnt  <= 16'h0000;
          timeoutQ <= 1'b0;
        end
        // Sync bytes are deliberately left out of the checksum.
        ST_SEQ, ST_LEN_H, ST_LEN_L: if (xfer) csum <= csum + TxByte;
        ST_REQ: begin
          toCnt <= '0;
          if (DataValid) payload <= DataIn;
        end
        ST_WAIT: begin
          if (DataValid) payload <= DataIn;
          else if (toCnt == TO_LIM) begin
            payload  <= 8'h00;
            timeoutQ <= 1'b1;
          end else toCnt <= toCnt + TW'(1);
        end
        ST_SEND: if (xfer) begin
          csum    <= csum + payload;
          byteCnt <= byteCnt + 16'd1;
        end
        ST_CSUM: if (xfer) seq <= seq + 8'd1;
        default: ;
      endcase
    end
  end

endmodule
